// File: rtl/cnt_capture_fifo_if.sv
// Bus between the counter-capture FIFO and its producer/consumer.
// slave is the FIFO side; master is the side that drives the counter and the read strobe.
interface cnt_capture_fifo_if #(
   parameter int AW = 2
);
   logic [7:0]  d_cnt;
   logic [2:0]  cnt_state;
   logic        rd_en;
   logic        clr_ovf;
   logic [7:0]  rd_data;
   logic        rd_dir;
   logic [2:0]  rd_state;
   logic        rd_valid;
   logic        empty;
   logic        full;
   logic [AW:0] count;
   logic        ovf;

   modport slave (
      input  d_cnt, cnt_state, rd_en, clr_ovf,
      output rd_data, rd_dir, rd_state, rd_valid, empty, full, count, ovf
   );

   modport master (
      output d_cnt, cnt_state, rd_en, clr_ovf,
      input  rd_data, rd_dir, rd_state, rd_valid, empty, full, count, ovf
   );
endinterface

// File: rtl/cnt_capture_fifo.sv
// Captures every change of the upstream counter value, tagged with direction and
// counter state, into a small FIFO that a consumer drains with a read strobe.
module cnt_capture_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic              clk,
   input logic              reset_n,
   cnt_capture_fifo_if.slave bus
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [11:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [7:0]    prev;
   logic          primed;

   logic [7:0]    diff;
   logic          dir;
   logic          push_req;
   logic          pop_ok;
   logic          push_ok;
   logic          overflow;
   logic [AW:0]   count_next;

   // A modular difference below 128 counts as an up step; 128 itself is treated as down.
   always_comb begin
      diff       = bus.d_cnt - prev;
      dir        = (diff != 8'd0) && !diff[7];
      push_req   = primed && (bus.d_cnt != prev);
      pop_ok     = bus.rd_en && !bus.empty;
      push_ok    = push_req && (!bus.full || pop_ok);
      overflow   = push_req && bus.full && !pop_ok;
      count_next = bus.count;
      if (push_ok && !pop_ok) begin
         count_next = bus.count + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_next = bus.count - 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wptr] <= {bus.cnt_state, dir, bus.d_cnt};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev         <= 8'h00;
         primed       <= 1'b0;
         wptr         <= '0;
         rptr         <= '0;
         bus.count    <= '0;
         bus.empty    <= 1'b1;
         bus.full     <= 1'b0;
         bus.ovf      <= 1'b0;
         bus.rd_data  <= 8'h00;
         bus.rd_dir   <= 1'b0;
         bus.rd_state <= 3'd0;
         bus.rd_valid <= 1'b0;
      end else begin
         prev      <= bus.d_cnt;
         primed    <= 1'b1;
         bus.count <= count_next;
         bus.empty <= (count_next == '0);
         bus.full  <= (count_next == DEPTH_C);

         if (push_ok) begin
            wptr <= wptr + 1'b1;
         end

         // A read of a full FIFO sees the old entry even when the same slot is rewritten this edge.
         bus.rd_valid <= pop_ok;
         if (pop_ok) begin
            rptr         <= rptr + 1'b1;
            bus.rd_data  <= mem[rptr][7:0];
            bus.rd_dir   <= mem[rptr][8];
            bus.rd_state <= mem[rptr][11:9];
         end

         if (overflow) begin
            bus.ovf <= 1'b1;
         end else if (bus.clr_ovf) begin
            bus.ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cnt_capture_fifo.sv
// Directed bench for cnt_capture_fifo: stimulus queues expected entries, a monitor
// pops and compares them whenever the FIFO presents a read.
module tb_cnt_capture_fifo;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   cnt_capture_fifo_if #(.AW(AW)) bus ();

   cnt_capture_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [11:0] sb [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        exp_pulse = 1'b0;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic check_flags(input string tag, input int cnt, input logic emp, input logic ful, input logic ov);
      check_output({tag, ".count"}, 32'(bus.count), 32'(cnt));
      check_output({tag, ".empty"}, 32'(bus.empty), 32'(emp));
      check_output({tag, ".full"},  32'(bus.full),  32'(ful));
      check_output({tag, ".ovf"},   32'(bus.ovf),   32'(ov));
   endtask

   // Drives one cycle of inputs; an expected entry is queued only after the edge that stores it.
   task automatic apply_stimulus(input logic [7:0] v, input logic [2:0] s, input logic rd,
                                 input logic clr, input logic exp_push, input logic exp_dir);
      bus.d_cnt     = v;
      bus.cnt_state = s;
      bus.rd_en     = rd;
      bus.clr_ovf   = clr;
      @(posedge clk);
      #1;
      bus.rd_en   = 1'b0;
      bus.clr_ovf = 1'b0;
      if (exp_push) sb.push_back({s, exp_dir, v});
   endtask

   task automatic read_n(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(bus.d_cnt, bus.cnt_state, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // A pulse is due one cycle after a read strobe that found the FIFO non-empty.
   initial begin
      logic [11:0] exp_entry;
      forever begin
         @(posedge clk);
         exp_pulse = reset_n && bus.rd_en && (sb.size() > 0);
         @(negedge clk);
         check_output("rd_valid", 32'(bus.rd_valid), 32'(exp_pulse));
         if (bus.rd_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL rd_entry: got 0x%0h, expected no entry", {bus.rd_state, bus.rd_dir, bus.rd_data});
            end else begin
               exp_entry = sb.pop_front();
               check_output("rd_entry", 32'({bus.rd_state, bus.rd_dir, bus.rd_data}), 32'(exp_entry));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.d_cnt     = 8'h10;
      bus.cnt_state = 3'd2;
      bus.rd_en     = 1'b0;
      bus.clr_ovf   = 1'b0;
      #12;
      check_flags("reset", 0, 1'b1, 1'b0, 1'b0);
      check_output("reset.rd_data", 32'(bus.rd_data), 32'h00);
      check_output("reset.rd_valid", 32'(bus.rd_valid), 32'h0);
      reset_n = 1'b1;

      $display("[TB] steady counter value");
      repeat (5) @(posedge clk);
      #1;
      check_flags("steady", 0, 1'b1, 1'b0, 1'b0);

      $display("[TB] basic up steps and read past empty");
      apply_stimulus(8'h11, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      apply_stimulus(8'h12, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      check_flags("two_entries", 2, 1'b0, 1'b0, 1'b0);
      read_n(3);
      check_flags("drained1", 0, 1'b1, 1'b0, 1'b0);

      $display("[TB] wrap and direction tags");
      apply_stimulus(8'hFE, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      apply_stimulus(8'hFF, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      apply_stimulus(8'h00, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      check_flags("wrap3", 3, 1'b0, 1'b0, 1'b0);
      read_n(3);
      apply_stimulus(8'hFF, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      read_n(1);
      apply_stimulus(8'h05, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1);
      apply_stimulus(8'h85, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      read_n(2);
      check_flags("drained2", 0, 1'b1, 1'b0, 1'b0);

      $display("[TB] overflow");
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(8'(8'h20 + i), 3'd5, 1'b0, 1'b0, i < 4, i != 0);
         if (i == 2) check_flags("ovf_fill3", 3, 1'b0, 1'b0, 1'b0);
         if (i == 3) check_flags("ovf_full", 4, 1'b0, 1'b1, 1'b0);
         if (i == 4) check_flags("ovf_drop5", 4, 1'b0, 1'b1, 1'b1);
      end
      check_flags("ovf_drop6", 4, 1'b0, 1'b1, 1'b1);
      read_n(4);
      check_flags("ovf_sticky", 0, 1'b1, 1'b0, 1'b1);
      apply_stimulus(bus.d_cnt, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      check_flags("ovf_clear", 0, 1'b1, 1'b0, 1'b0);

      $display("[TB] push and pop while full");
      for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h30 + i), 3'd6, 1'b0, 1'b0, 1'b1, 1'b1);
      check_flags("full2", 4, 1'b0, 1'b1, 1'b0);
      apply_stimulus(8'h34, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1);
      check_flags("full_rw", 4, 1'b0, 1'b1, 1'b0);
      apply_stimulus(8'h35, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
      check_flags("set_wins", 4, 1'b0, 1'b1, 1'b1);
      read_n(4);
      check_flags("drained3", 0, 1'b1, 1'b0, 1'b1);
      apply_stimulus(bus.d_cnt, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
      check_flags("ovf_clear2", 0, 1'b1, 1'b0, 1'b0);

      $display("[TB] push and pop while empty");
      apply_stimulus(8'h40, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);
      check_flags("empty_rw", 1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(8'h41, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
      apply_stimulus(8'h42, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
      check_flags("pre_reset", 3, 1'b0, 1'b0, 1'b0);

      $display("[TB] asynchronous reset mid-operation");
      #3;
      reset_n = 1'b0;
      sb.delete();
      #1;
      check_flags("async_reset", 0, 1'b1, 1'b0, 1'b0);
      check_output("async_reset.rd_data", 32'(bus.rd_data), 32'h00);
      check_output("async_reset.rd_state", 32'(bus.rd_state), 32'h0);
      bus.d_cnt     = 8'h77;
      bus.cnt_state = 3'd7;
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_flags("prime_edge", 0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_flags("post_prime", 0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(8'h78, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1);
      check_flags("post_reset_push", 1, 1'b0, 1'b0, 1'b0);
      read_n(1);
      repeat (2) @(posedge clk);
      #1;
      check_flags("final", 0, 1'b1, 1'b0, 1'b0);
      check_output("scoreboard_left", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
